// File: rtl/seg7_scan.sv
// Six-digit multiplexed common-anode 7-segment driver: frame snapshot of the BCD
// word, per-slot anti-ghosting blank, and field blinking for setting modes.
module seg7_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int BLINK_DIV = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] time_date,
  input  logic [1:0]  blink,
  output logic [7:0]  seg,
  output logic [5:0]  dig_sel
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_V   = SW'(BLANK_CYC);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_DIV - 1);

  logic [SW-1:0] slot_cnt;
  logic [2:0]    dig_idx;
  logic [23:0]   snap;
  logic [BW-1:0] blk_cnt;
  logic          blk_phase;
  logic [1:0]    blink_q;

  logic          frame_start;
  logic [23:0]   snap_eff;
  logic [3:0]    nib;
  logic          in_blank;
  logic          in_field;
  logic [7:0]    seg_nxt;
  logic [5:0]    sel_nxt;
  logic [7:0]    seg_p1;
  logic [5:0]    dig_sel_p1;

  function automatic logic [6:0] seg7_decode(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'd0:    r = 7'h40;
      4'd1:    r = 7'h79;
      4'd2:    r = 7'h24;
      4'd3:    r = 7'h30;
      4'd4:    r = 7'h19;
      4'd5:    r = 7'h12;
      4'd6:    r = 7'h02;
      4'd7:    r = 7'h78;
      4'd8:    r = 7'h00;
      4'd9:    r = 7'h10;
      default: r = 7'h3F;
    endcase
    return r;
  endfunction

  // Scan position, frame snapshot and blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      dig_idx   <= '0;
      snap      <= '0;
      blk_cnt   <= '0;
      blk_phase <= 1'b0;
      blink_q   <= 2'd0;
    end else begin
      if (frame_start) snap <= time_date;
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        dig_idx  <= (dig_idx == 3'd5) ? 3'd0 : dig_idx + 3'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (blink != blink_q) begin
        blink_q   <= blink;
        blk_cnt   <= '0;
        blk_phase <= 1'b0;
      end else if (blk_cnt == BLK_LAST) begin
        blk_cnt   <= '0;
        blk_phase <= ~blk_phase;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end
  end

  // The snapshot bypass keeps the first slot of a frame on the new word even with no blank interval
  always_comb begin
    frame_start = (dig_idx == 3'd0) && (slot_cnt == '0);
    snap_eff    = frame_start ? time_date : snap;
    case (dig_idx)
      3'd0:    nib = snap_eff[3:0];
      3'd1:    nib = snap_eff[7:4];
      3'd2:    nib = snap_eff[11:8];
      3'd3:    nib = snap_eff[15:12];
      3'd4:    nib = snap_eff[19:16];
      default: nib = snap_eff[23:20];
    endcase
    in_blank = (BLANK_CYC != 0) && (slot_cnt < BLANK_V);
    in_field = (blink_q != 2'd0) && (dig_idx[2:1] == blink_q - 2'd1);
    seg_nxt  = 8'hFF;
    sel_nxt  = 6'h3F;
    if (!in_blank) begin
      sel_nxt = ~(6'b1 << dig_idx);
      if (!(blk_phase && in_field)) begin
        seg_nxt = {~((dig_idx == 3'd2) || (dig_idx == 3'd4)), seg7_decode(nib)};
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p1     <= 8'hFF;
      dig_sel_p1 <= 6'h3F;
    end else begin
      seg_p1     <= seg_nxt;
      dig_sel_p1 <= sel_nxt;
    end
  end

  assign seg     = seg_p1;
  assign dig_sel = dig_sel_p1;

endmodule
